regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters.

---
 rtl/regfile_write_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters. Port A is the ALU writeback. Port B is the load/memory
//   writeback, and it always carries the older instruction.
//   The arbiter resolves contention using three mechanisms:
//     - a round-robin pointer,
//     - a same-address ordering rule, so that the older write lands first,
//     - a per-port starvation guard.
//   The write outputs are registered and drive the register file directly.
//
// Parameters:
//   DW        data width of the write data
//   AW        register address width (2**AW registers)
//   MAX_WAIT  cycles a valid, ungranted port may wait before it is forced
//             to win (must be >= 1)
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   i_a_valid  in   1   ALU write request
//   o_a_ready  out  1   ALU request accepted this cycle (combinational)
//   i_a_addr   in   AW  ALU destination register
//   i_a_data   in   DW  ALU write data
//   i_b_valid  in   1   MEM write request
//   o_b_ready  out  1   MEM request accepted this cycle (combinational)
//   i_b_addr   in   AW  MEM destination register
//   i_b_data   in   DW  MEM write data
//   o_wr_en    out  1   register file write enable (registered)
//   o_wr_addr  out  AW  register file write address (registered)
//   o_wr_data  out  DW  register file write data (registered)
//   o_wr_src   out  1   source of the current write: 0=A, 1=B (registered)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_a_valid,
  output logic          o_a_ready,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_wr_src
);

  // The wait counters only need to reach MAX_WAIT.
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

  rr_e           r_rr_ptr;
  logic [WW-1:0] r_wait_a;
  logic [WW-1:0] r_wait_b;

  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_wr_src;

  logic          w_same_addr;
  logic          w_a_sat;
  logic          w_b_sat;
  logic          w_grant_a;
  logic          w_grant_b;

  // Decode the contention conditions used by the grant priority.
  always_comb begin
    // A shared address of register 0 is not an ordering hazard:
    // writes to register 0 are discarded anyway.
    w_same_addr = i_a_valid && i_b_valid &&
                  (i_a_addr == i_b_addr) && (i_a_addr != {AW{1'b0}});
    w_a_sat     = (r_wait_a == WAIT_MAX);
    w_b_sat     = (r_wait_b == WAIT_MAX);
  end

  // Grant selection, at most one port per cycle, highest priority first.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (i_a_valid && !i_b_valid) begin
      w_grant_a = 1'b1;
    end else if (!i_a_valid && i_b_valid) begin
      w_grant_b = 1'b1;
    end else if (i_a_valid && i_b_valid) begin
      if (w_same_addr) begin
        // B is the older instruction, so it must reach the register first.
        w_grant_b = 1'b1;
      end else if (w_b_sat) begin
        // When both ports are saturated, B wins this check too.
        w_grant_b = 1'b1;
      end else if (w_a_sat) begin
        w_grant_a = 1'b1;
      end else if (r_rr_ptr == RR_B) begin
        w_grant_b = 1'b1;
      end else begin
        w_grant_a = 1'b1;
      end
    end else begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
    end
  end

  // Ready is the grant itself; the handshake completes on the next edge.
  always_comb begin
    o_a_ready = w_grant_a;
    o_b_ready = w_grant_b;
  end

  // Round-robin pointer: point away from the last winner, except when the
  // winner was chosen by the same-address ordering rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= RR_A;
    end else if (w_same_addr) begin
      r_rr_ptr <= r_rr_ptr;
    end else if (w_grant_a) begin
      r_rr_ptr <= RR_B;
    end else if (w_grant_b) begin
      r_rr_ptr <= RR_A;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Starvation counter for port A: counts cycles spent valid but not
  // granted, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_a <= {WW{1'b0}};
    end else if (!i_a_valid || w_grant_a) begin
      r_wait_a <= {WW{1'b0}};
    end else if (!w_a_sat) begin
      r_wait_a <= r_wait_a + WAIT_ONE;
    end else begin
      r_wait_a <= r_wait_a;
    end
  end

  // Starvation counter for port B: same behaviour as the port A counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_b <= {WW{1'b0}};
    end else if (!i_b_valid || w_grant_b) begin
      r_wait_b <= {WW{1'b0}};
    end else if (!w_b_sat) begin
      r_wait_b <= r_wait_b + WAIT_ONE;
    end else begin
      r_wait_b <= r_wait_b;
    end
  end

  // Registered write port.
  // An accepted request to register 0 still updates addr/data/src, but its
  // write enable stays low. When nothing is granted, only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= {AW{1'b0}};
      r_wr_data <= {DW{1'b0}};
      r_wr_src  <= 1'b0;
    end else if (w_grant_a) begin
      r_wr_en   <= (i_a_addr != {AW{1'b0}});
      r_wr_addr <= i_a_addr;
      r_wr_data <= i_a_data;
      r_wr_src  <= 1'b0;
    end else if (w_grant_b) begin
      r_wr_en   <= (i_b_addr != {AW{1'b0}});
      r_wr_addr <= i_b_addr;
      r_wr_data <= i_b_data;
      r_wr_src  <= 1'b1;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= r_wr_addr;
      r_wr_data <= r_wr_data;
      r_wr_src  <= r_wr_src;
    end
  end

  // Drive the output ports from their registers.
  always_comb begin
    o_wr_en   = r_wr_en;
    o_wr_addr = r_wr_addr;
    o_wr_data = r_wr_data;
    o_wr_src  = r_wr_src;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed vectors for regfile_write_arbiter, instantiated with MAX_WAIT=2.
// Each vector carries its hand-computed ready values. An expected write is
// queued for every accepted request to a non-zero register. A monitor pops
// that queue and compares whenever the DUT raises wr_en.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          src;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_src;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks;
  int  n_pass;

  regfile_write_arbiter #(
    .DW       (DW),
    .AW       (AW),
    .MAX_WAIT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_valid (a_valid),
    .o_a_ready (a_ready),
    .i_a_addr  (a_addr),
    .i_a_data  (a_data),
    .i_b_valid (b_valid),
    .o_b_ready (b_ready),
    .i_b_addr  (b_addr),
    .i_b_data  (b_data),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_wr_src  (wr_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge, and check every write the DUT presents.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h src=%0d expected no write",
                 wr_addr, wr_data, wr_src);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", wr_data, mon_e.data);
        chk("wr_src", 32'(wr_src), 32'(mon_e.src));
      end
    end
  end

  // Drive one cycle of requests, check ready, and queue the expected writes.
  task automatic cyc(input string nm,
                     input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                     input logic ear, input logic ebr);
    wr_t e;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk({nm, "_a_ready"}, 32'(a_ready), 32'(ear));
    chk({nm, "_b_ready"}, 32'(b_ready), 32'(ebr));
    if (ear && aa != 5'd0) begin
      e.addr = aa; e.data = ad; e.src = 1'b0;
      exp_q.push_back(e);
    end
    if (ebr && ba != 5'd0) begin
      e.addr = ba; e.data = bd; e.src = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    a_valid  = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid  = 1'b0; b_addr = 5'd0; b_data = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data,      32'd0);
    chk("rst_wr_src",  32'(wr_src),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // One A write, then a mid-cycle reset while A is still requesting
    cyc("v1", 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h22;
    b_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en",   32'(wr_en),   32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", wr_data,      32'd0);
    chk("midrst_wr_src",  32'(wr_src),  32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    rst_n   = 1'b1;

    // After reset the pointer is back on A: round robin gives A,B,A,B
    cyc("rr1", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    cyc("rr2", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    cyc("rr3", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
    cyc("rr4", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);

    // Single port A
    cyc("single", 1'b1, 5'd9, 32'h6, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Same address: the older B write first, then A (reg7 ends as 1)
    cyc("same1", 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0, 1'b1);
    cyc("same2", 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Register 0: accepted, but no write enable on the following cycle
    cyc("reg0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5, 1'b0, 1'b1);
    cyc("idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("reg0_wr_en", 32'(wr_en), 32'd0);

    // Point rr at B, then starve A through repeated same-address collisions
    cyc("pre", 1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    cyc("starv1", 1'b1, 5'd5, 32'h50, 1'b1, 5'd5, 32'h60, 1'b0, 1'b1);
    cyc("starv2", 1'b1, 5'd5, 32'h50, 1'b1, 5'd5, 32'h61, 1'b0, 1'b1);
    cyc("starv3", 1'b1, 5'd5, 32'h50, 1'b1, 5'd5, 32'h62, 1'b0, 1'b1);
    // Addresses now differ: A is saturated, so it wins although rr points at B
    cyc("starv4", 1'b1, 5'd5, 32'h50, 1'b1, 5'd6, 32'h70, 1'b1, 1'b0);
    cyc("starv5", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h70, 1'b0, 1'b1);

    cyc("drain1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc("drain2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
